// File: rtl/alu_acc_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_acc_stage
//  Brief    : Registered accumulator stage fed by the 16-bit inverter. Performs
//             load / add / subtract / negate / complement / clear into an
//             accumulator and presents the result plus Z/N/C/V/ERR flags on a
//             valid/ready output port (1-cycle latency, 1 result per cycle).
//  Options  : `define ALU_ACC_SAT_EN makes ADD, SUB and NEG saturate on signed
//             overflow instead of wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_acc_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] b_inv,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_err
);

  localparam logic [2:0] C_OP_NOP  = 3'b000;
  localparam logic [2:0] C_OP_LOAD = 3'b001;
  localparam logic [2:0] C_OP_ADD  = 3'b010;
  localparam logic [2:0] C_OP_SUB  = 3'b011;
  localparam logic [2:0] C_OP_NEG  = 3'b100;
  localparam logic [2:0] C_OP_NOT  = 3'b101;
  localparam logic [2:0] C_OP_CLR  = 3'b110;

  localparam logic [WIDTH:0]   C_ONE = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef ALU_ACC_SAT_EN
  localparam logic [WIDTH-1:0] C_MAX = {1'b0, {(WIDTH-1){1'b1}}};
`endif

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             err_q, err_d;

  logic             w_accept;
  logic [WIDTH:0]   w_sum_add;
  logic [WIDTH:0]   w_sum_sub;
  logic [WIDTH:0]   w_sum_neg;
  logic [WIDTH-1:0] w_new_acc;
  logic             w_new_c;
  logic             w_new_v;
  logic             w_new_err;

  assign res_valid = (state_q == ST_FULL);
  // A full register can take a new operation only when it is drained in the same edge.
  assign in_ready  = !res_valid || res_ready;
  assign w_accept  = in_valid && in_ready;

  assign result   = acc_q;
  assign flag_z   = z_q;
  assign flag_n   = n_q;
  assign flag_c   = c_q;
  assign flag_v   = v_q;
  assign flag_err = err_q;

  // Operation datapath: new accumulator value and C/V/ERR for the presented opcode.
  always_comb begin
    w_sum_add = {1'b0, acc_q} + {1'b0, b};
    w_sum_sub = {1'b0, acc_q} + {1'b0, b_inv} + C_ONE;
    w_sum_neg = {1'b0, b_inv} + C_ONE;
    w_new_acc = acc_q;
    w_new_c   = 1'b0;
    w_new_v   = 1'b0;
    w_new_err = 1'b0;
    case (opcode)
      C_OP_NOP:  w_new_acc = acc_q;
      C_OP_LOAD: w_new_acc = b;
      C_OP_ADD: begin
        w_new_acc = w_sum_add[WIDTH-1:0];
        w_new_c   = w_sum_add[WIDTH];
        w_new_v   = (acc_q[WIDTH-1] == b[WIDTH-1]) &&
                    (w_sum_add[WIDTH-1] != acc_q[WIDTH-1]);
      end
      C_OP_SUB: begin
        w_new_acc = w_sum_sub[WIDTH-1:0];
        w_new_c   = w_sum_sub[WIDTH];
        w_new_v   = (acc_q[WIDTH-1] != b[WIDTH-1]) &&
                    (w_sum_sub[WIDTH-1] != acc_q[WIDTH-1]);
      end
      C_OP_NEG: begin
        w_new_acc = w_sum_neg[WIDTH-1:0];
        w_new_c   = w_sum_neg[WIDTH];
        w_new_v   = (b == C_MIN);
      end
      C_OP_NOT:  w_new_acc = b_inv;
      C_OP_CLR:  w_new_acc = '0;
      default: begin
        // Reserved opcode: accumulator untouched, error flag raised.
        w_new_acc = acc_q;
        w_new_err = 1'b1;
      end
    endcase
`ifdef ALU_ACC_SAT_EN
    // Overflow direction: NEG can only overflow positive; ADD/SUB overflow
    // toward the sign opposite to the original accumulator.
    if (w_new_v) begin
      if ((opcode == C_OP_NEG) || !acc_q[WIDTH-1]) begin
        w_new_acc = C_MAX;
      end else begin
        w_new_acc = C_MIN;
      end
    end
`endif
  end

  // Next-state and register update: everything moves only on an accepted request.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
    v_d     = v_q;
    err_d   = err_q;
    if (w_accept) begin
      state_d = ST_FULL;
      acc_d   = w_new_acc;
      z_d     = (w_new_acc == '0);
      n_d     = w_new_acc[WIDTH-1];
      c_d     = w_new_c;
      v_d     = w_new_v;
      err_d   = w_new_err;
    end else if (res_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      acc_q   <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      v_q     <= v_d;
      err_q   <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_acc_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_acc_stage
//  Brief    : Directed, table-driven self-checking bench for alu_acc_stage,
//             plus hand-written reset and backpressure sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_acc_stage;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] b_inv;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;
  logic             flag_err;

  int n_tests;
  int n_fail;

  alu_acc_stage #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .b         (b),
    .b_inv     (b_inv),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .flag_err  (flag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector: opcode and operand in, result and {Z,N,C,V,ERR} out.
  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] exp_res;
    logic [4:0]       exp_flags;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [WIDTH-1:0] val,
                       input logic rr);
    in_valid  = v;
    opcode    = op;
    b         = val;
    b_inv     = ~val;
    res_ready = rr;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Accumulator carries through the table, so each row depends on the previous.
    vecs[0]  = '{3'b001, 16'h00FF, 16'h00FF, 5'b00000}; // LOAD
    vecs[1]  = '{3'b010, 16'h0001, 16'h0100, 5'b00000}; // ADD
    vecs[2]  = '{3'b001, 16'h7FFF, 16'h7FFF, 5'b00000}; // LOAD
`ifdef ALU_ACC_SAT_EN
    vecs[3]  = '{3'b010, 16'h0001, 16'h7FFF, 5'b00010}; // ADD pos overflow sat
`else
    vecs[3]  = '{3'b010, 16'h0001, 16'h8000, 5'b01010}; // ADD pos overflow wrap
`endif
    vecs[4]  = '{3'b001, 16'h0000, 16'h0000, 5'b10000}; // LOAD 0
    vecs[5]  = '{3'b011, 16'h0001, 16'hFFFF, 5'b01000}; // SUB borrow
    vecs[6]  = '{3'b100, 16'h0000, 16'h0000, 5'b10100}; // NEG 0
`ifdef ALU_ACC_SAT_EN
    vecs[7]  = '{3'b100, 16'h8000, 16'h7FFF, 5'b00010}; // NEG min sat
`else
    vecs[7]  = '{3'b100, 16'h8000, 16'h8000, 5'b01010}; // NEG min wrap
`endif
    vecs[8]  = '{3'b101, 16'h00F0, 16'hFF0F, 5'b01000}; // NOT
    vecs[9]  = '{3'b110, 16'hABCD, 16'h0000, 5'b10000}; // CLR
    vecs[10] = '{3'b010, 16'hFFFF, 16'hFFFF, 5'b01000}; // ADD no carry
    vecs[11] = '{3'b010, 16'h0001, 16'h0000, 5'b10100}; // ADD carry wrap to 0
    vecs[12] = '{3'b011, 16'h0000, 16'h0000, 5'b10100}; // SUB 0, no borrow
    vecs[13] = '{3'b001, 16'h8000, 16'h8000, 5'b01000}; // LOAD min
`ifdef ALU_ACC_SAT_EN
    vecs[14] = '{3'b011, 16'h0001, 16'h8000, 5'b01110}; // SUB neg overflow sat
    vecs[15] = '{3'b000, 16'h5555, 16'h8000, 5'b01000}; // NOP
    vecs[16] = '{3'b111, 16'h1234, 16'h8000, 5'b01001}; // reserved
`else
    vecs[14] = '{3'b011, 16'h0001, 16'h7FFF, 5'b00110}; // SUB neg overflow wrap
    vecs[15] = '{3'b000, 16'h5555, 16'h7FFF, 5'b00000}; // NOP
    vecs[16] = '{3'b111, 16'h1234, 16'h7FFF, 5'b00001}; // reserved
`endif
    vecs[17] = '{3'b001, 16'h1234, 16'h1234, 5'b00000}; // LOAD clears err

    // Reset held two cycles with a request present: request must be dropped.
    rst = 1'b1;
    drive(1'b1, 3'b001, 16'hBEEF, 1'b1);
    step();
    step();
    rst = 1'b0;
    drive(1'b0, 3'b000, 16'h0000, 1'b1);
    check("reset res_valid", {31'd0, res_valid}, 32'd0);
    check("reset result", {16'd0, result}, 32'h0000);
    check("reset flags", {27'd0, flag_z, flag_n, flag_c, flag_v, flag_err}, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);

    // Table: one accept per cycle with downstream always ready.
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].opb, 1'b1);
      check($sformatf("v%0d in_ready", i), {31'd0, in_ready}, 32'd1);
      step();
      check($sformatf("v%0d res_valid", i), {31'd0, res_valid}, 32'd1);
      check($sformatf("v%0d result", i), {16'd0, result}, {16'd0, vecs[i].exp_res});
      check($sformatf("v%0d flags", i),
            {27'd0, flag_z, flag_n, flag_c, flag_v, flag_err}, {27'd0, vecs[i].exp_flags});
    end

    // Drain: no request, downstream ready -> EMPTY, result held.
    drive(1'b0, 3'b000, 16'h0000, 1'b1);
    step();
    check("drain res_valid", {31'd0, res_valid}, 32'd0);
    check("drain result", {16'd0, result}, 32'h1234);

    // Backpressure: load with downstream stalled, then offer ADD while full.
    drive(1'b1, 3'b001, 16'h0010, 1'b0);
    step();
    check("bp load valid", {31'd0, res_valid}, 32'd1);
    check("bp load result", {16'd0, result}, 32'h0010);
    drive(1'b1, 3'b010, 16'h0005, 1'b0);
    check("bp in_ready low", {31'd0, in_ready}, 32'd0);
    step();
    step();
    check("bp held result", {16'd0, result}, 32'h0010);
    check("bp held valid", {31'd0, res_valid}, 32'd1);
    check("bp in_ready still low", {31'd0, in_ready}, 32'd0);

    // Release for one cycle with the request still present: replaced in same edge.
    res_ready = 1'b1;
    #1;
    check("bp in_ready high", {31'd0, in_ready}, 32'd1);
    step();
    check("bp replace result", {16'd0, result}, 32'h0015);
    check("bp replace valid", {31'd0, res_valid}, 32'd1);
    drive(1'b0, 3'b000, 16'h0000, 1'b0);
    step();
    check("bp idle hold", {16'd0, result}, 32'h0015);
    check("bp idle valid", {31'd0, res_valid}, 32'd1);

    // Reset while full clears everything.
    rst = 1'b1;
    drive(1'b1, 3'b111, 16'h0000, 1'b1);
    step();
    rst = 1'b0;
    drive(1'b0, 3'b000, 16'h0000, 1'b0);
    check("reset2 res_valid", {31'd0, res_valid}, 32'd0);
    check("reset2 result", {16'd0, result}, 32'h0000);
    check("reset2 flags", {27'd0, flag_z, flag_n, flag_c, flag_v, flag_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
